// File: rtl/spi_switch_arbiter_pkg.sv
// Shared types and width helpers for the SPI bus arbiter.
package spi_switch_arbiter_pkg;

  // Arbiter FSM: bus free, idle guard before handing over, bus owned by one port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_OWNED = 2'd2
  } state_e;

  // Width of a port index (at least one bit).
  function automatic int idx_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  // Width of the shared guard/watchdog counter.
  function automatic int cnt_w(input int guard, input int tmo);
    int m;
    m = (guard > tmo) ? guard : tmo;
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/spi_switch_arbiter_if.sv
// Per-port request/grant handshake plus the shared physical SPI bus.
//
// Handshake: req is a level request and grant a registered level acknowledge.
// A port owns the bus exactly while its grant bit is high. The owner releases by
// dropping req while its ss_L is high; the arbiter never takes the bus away while
// the owner's ss_L is low.
interface spi_switch_arbiter_if #(
  parameter int PORTS = 3
);
  import spi_switch_arbiter_pkg::*;

  localparam int IDX_W = idx_w(PORTS);

  logic [PORTS-1:0] req;
  logic [PORTS-1:0] grant;
  logic             force_en;
  logic [IDX_W-1:0] force_sel;
  logic             busy;
  logic             timeout;
  logic             proto_err;
  logic             mosi;
  logic             sck;
  logic             ss_L;
  logic             miso;
  logic [PORTS-1:0] mosi_ports;
  logic [PORTS-1:0] sck_ports;
  logic [PORTS-1:0] ss_L_ports;
  logic [PORTS-1:0] miso_ports;

  // Arbiter side.
  modport slave (
    input  req, force_en, force_sel, miso, mosi_ports, sck_ports, ss_L_ports,
    output grant, busy, timeout, proto_err, mosi, sck, ss_L, miso_ports
  );

  // Requester / bus side.
  modport master (
    output req, force_en, force_sel, miso, mosi_ports, sck_ports, ss_L_ports,
    input  grant, busy, timeout, proto_err, mosi, sck, ss_L, miso_ports
  );

endinterface

// File: rtl/spi_switch_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import spi_switch_arbiter_pkg::*;
#(
  parameter int PORTS = 3,
  parameter int IDX_W = idx_w(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] j;

  // Scan from farthest to nearest so the closest hit to ptr wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    j       = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      j = IDX_W'((int'(ptr_i) + k) % PORTS);
      if (req_i[j]) begin
        idx_o   = j;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_switch_arbiter.sv
// SPI crossbar arbiter: round-robin ownership of one SPI bus among PORTS masters,
// with guard cycles between owners, kernel force-select and optional watchdog.
module spi_switch_arbiter
  import spi_switch_arbiter_pkg::*;
#(
  parameter int PORTS          = 3,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 0,
  parameter bit SCK_IDLE       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_L,
  spi_switch_arbiter_if.slave  bus,
  output state_e               state_o
);

  localparam int IDX_W = idx_w(PORTS);
  localparam int CNT_W = cnt_w(GUARD_CYCLES, TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic             timeout_q, timeout_d;
  logic             proto_err_q, proto_err_d;
  logic             perr_seen_q, perr_seen_d;

  logic [PORTS-1:0] cand;
  logic [IDX_W-1:0] pick_idx, ptr_next;
  logic             pick_valid, owner_req, owner_ss, preempt, tmo_hit, revoke;

  // Candidate set: raw requests, narrowed to force_sel while the kernel forces.
  always_comb begin
    cand = '0;
    for (int i = 0; i < PORTS; i++) begin
      cand[i] = bus.req[i] & (!bus.force_en | (bus.force_sel == IDX_W'(i)));
    end
  end

  rr_pick #(.PORTS(PORTS), .IDX_W(IDX_W)) u_pick (
    .req_i   (cand),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign owner_req = bus.req[owner_q];
  assign owner_ss  = bus.ss_L_ports[owner_q];
  assign preempt   = bus.force_en && (bus.force_sel != owner_q);
  assign tmo_hit   = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // Ownership may only end on a transaction boundary (owner ss_L high).
  assign revoke    = owner_ss && (!owner_req || preempt || tmo_hit);
  assign ptr_next  = (owner_q == IDX_W'(PORTS - 1)) ? '0 : owner_q + 1'b1;

  // Next-state, counter and grant logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    timeout_d   = 1'b0;
    proto_err_d = 1'b0;
    perr_seen_d = perr_seen_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          cnt_d   = CNT_W'(GUARD_CYCLES - 1);
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (!cand[owner_q]) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          grant_d     = PORTS'(1) << owner_q;
          perr_seen_d = 1'b0;
          state_d     = ST_OWNED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OWNED: begin
        if (!owner_ss) begin
          // Mid-transaction: watchdog restarts; a dropped req is a protocol error.
          cnt_d = '0;
          if (!owner_req && !perr_seen_q) begin
            proto_err_d = 1'b1;
            perr_seen_d = 1'b1;
          end
        end else if (revoke) begin
          timeout_d   = owner_req && !preempt;
          grant_d     = '0;
          rr_ptr_d    = ptr_next;
          cnt_d       = '0;
          perr_seen_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
      perr_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
      perr_seen_q <= perr_seen_d;
    end
  end

  // Bus pins follow the registered one-hot grant; no grant gives idle levels.
  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.timeout    = timeout_q;
  assign bus.proto_err  = proto_err_q;
  assign bus.mosi       = |(grant_q & bus.mosi_ports);
  assign bus.sck        = (|grant_q) ? |(grant_q & bus.sck_ports) : SCK_IDLE;
  assign bus.ss_L       = (|grant_q) ? |(grant_q & bus.ss_L_ports) : 1'b1;
  assign bus.miso_ports = grant_q & {PORTS{bus.miso}};
  assign state_o        = state_q;

endmodule

// File: tb/tb_spi_switch_arbiter.sv
// Directed bench for spi_switch_arbiter with an expected-grant scoreboard.
module tb_spi_switch_arbiter;
  import spi_switch_arbiter_pkg::*;

  localparam int PORTS = 3;
  localparam int GUARD = 2;
  localparam int TMO   = 8;

  logic   clk;
  logic   rst_L;
  state_e state_dbg;
  int     checks = 0;
  int     errors = 0;
  logic [PORTS-1:0] exp_q[$];

  spi_switch_arbiter_if #(.PORTS(PORTS)) bus ();

  spi_switch_arbiter #(
    .PORTS(PORTS), .GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TMO), .SCK_IDLE(1'b0)
  ) dut (
    .clk(clk), .rst_L(rst_L), .bus(bus), .state_o(state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_defaults();
    bus.req        = '0;
    bus.force_en   = 1'b0;
    bus.force_sel  = '0;
    bus.miso       = 1'b0;
    bus.mosi_ports = '1;
    bus.sck_ports  = '1;
    bus.ss_L_ports = '1;
  endtask

  task automatic do_reset();
    rst_L = 1'b0;
    drive_defaults();
    step(3);
    rst_L = 1'b1;
    step(1);
  endtask

  // Wait for a grant, pop the scoreboard and compare; reports zero-grant cycles.
  task automatic wait_grant(input string tag, input int budget, output int waited,
                            output logic [PORTS-1:0] got);
    logic [PORTS-1:0] exp_g;
    logic             idle_ok;
    waited  = 0;
    idle_ok = 1'b1;
    while (bus.grant == '0 && waited < budget) begin
      if (bus.ss_L !== 1'b1 || bus.sck !== 1'b0 || bus.mosi !== 1'b0) idle_ok = 1'b0;
      step(1);
      waited++;
    end
    got = bus.grant;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s_sb: observed grant %0h with empty expected queue", tag, got);
    end else begin
      exp_g = exp_q.pop_front();
      check(tag, got, exp_g);
    end
    check({tag, "_idle_bus"}, idle_ok, 1);
  endtask

  initial begin
    int               w;
    int               held;
    int               pulses;
    logic             ok;
    logic [PORTS-1:0] g;

    // 1. Reset state, with port inputs high so idle levels are meaningful.
    rst_L = 1'b0;
    drive_defaults();
    bus.miso = 1'b1;
    step(1);
    check("rst_grant", bus.grant, 0);
    check("rst_ss_L", bus.ss_L, 1);
    check("rst_sck", bus.sck, 0);
    check("rst_mosi", bus.mosi, 0);
    check("rst_miso_ports", bus.miso_ports, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_proto_err", bus.proto_err, 0);
    check("rst_state", state_dbg, ST_IDLE);
    rst_L = 1'b1;
    bus.miso = 1'b0;
    step(3);
    check("idle_no_req_grant", bus.grant, 0);

    // 2. Single request, latency and routing.
    bus.req = 3'b010;
    exp_q.push_back(3'b010);
    wait_grant("t2_grant", 10, w, g);
    check("t2_latency", w, GUARD + 1);
    check("t2_busy", bus.busy, 1);
    check("t2_state", state_dbg, ST_OWNED);
    bus.miso       = 1'b1;
    bus.ss_L_ports = 3'b101;
    bus.sck_ports  = 3'b010;
    bus.mosi_ports = 3'b010;
    #1;
    check("t2_miso_ports", bus.miso_ports, 3'b010);
    check("t2_ss_L", bus.ss_L, 0);
    check("t2_sck", bus.sck, 1);
    check("t2_mosi", bus.mosi, 1);
    bus.sck_ports  = 3'b101;
    bus.mosi_ports = 3'b101;
    #1;
    check("t2_sck_other", bus.sck, 0);
    check("t2_mosi_other", bus.mosi, 0);
    step(1);
    bus.ss_L_ports = '1;
    bus.req        = '0;
    bus.miso       = 1'b0;
    step(1);
    check("t2_release_grant", bus.grant, 0);
    check("t2_release_busy", bus.busy, 0);

    // 3. All ports requesting: round-robin order from pointer 0.
    do_reset();
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    bus.req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_grant($sformatf("t3_grant%0d", i), 12, w, g);
      check($sformatf("t3_gap%0d", i), w, GUARD + 1);
      bus.ss_L_ports = ~g;
      step(2);
      bus.ss_L_ports = '1;
      bus.req        = bus.req & ~g;
      step(1);
      check($sformatf("t3_release%0d", i), bus.grant, 0);
      if (i < 3) bus.req = bus.req | g;
      else       bus.req = '0;
    end

    // 4. Owner drops req mid-transaction: one proto_err pulse, grant held.
    bus.req = 3'b001;
    exp_q.push_back(3'b001);
    wait_grant("t4_grant", 12, w, g);
    bus.ss_L_ports = 3'b110;
    step(1);
    bus.req = '0;
    pulses  = 0;
    ok      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      if (bus.proto_err === 1'b1) pulses++;
      if (bus.grant !== 3'b001) ok = 1'b0;
    end
    check("t4_perr_pulses", pulses, 1);
    check("t4_grant_held", ok, 1);
    bus.ss_L_ports = '1;
    step(1);
    check("t4_release_grant", bus.grant, 0);
    check("t4_perr_low", bus.proto_err, 0);

    // 5. Watchdog: owner idles with ss_L high for TMO cycles.
    bus.req = 3'b010;
    exp_q.push_back(3'b010);
    wait_grant("t5_grant", 12, w, g);
    held = 0;
    while (bus.grant != '0 && held < 20) begin
      step(1);
      held++;
    end
    check("t5_hold_cycles", held, TMO);
    check("t5_timeout_pulse", bus.timeout, 1);
    bus.req = '0;
    step(1);
    check("t5_timeout_clear", bus.timeout, 0);
    check("t5_grant_after", bus.grant, 0);

    // 6. Force-select while port0 is mid-transfer.
    bus.req = 3'b001;
    exp_q.push_back(3'b001);
    wait_grant("t6_own0", 12, w, g);
    bus.ss_L_ports = 3'b110;
    step(1);
    bus.force_en  = 1'b1;
    bus.force_sel = 2'd2;
    bus.req       = 3'b111;
    ok            = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      if (bus.grant !== 3'b001) ok = 1'b0;
    end
    check("t6_no_midtxn_revoke", ok, 1);
    bus.ss_L_ports = '1;
    exp_q.push_back(3'b100);
    step(1);
    check("t6_preempt_release", bus.grant, 0);
    wait_grant("t6_forced", 12, w, g);
    check("t6_forced_gap", w, GUARD + 1);
    bus.ss_L_ports = 3'b011;
    step(1);
    bus.ss_L_ports = '1;
    bus.req        = 3'b011;
    step(1);
    check("t6_forced_release", bus.grant, 0);
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (bus.grant !== 3'b000 || bus.busy !== 1'b0) ok = 1'b0;
    end
    check("t6_req1_ignored", ok, 1);
    bus.force_sel = 2'd3;
    bus.req       = 3'b111;
    ok            = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (bus.grant !== 3'b000 || bus.busy !== 1'b0) ok = 1'b0;
    end
    check("t6_sel_out_of_range", ok, 1);
    bus.force_en = 1'b0;
    exp_q.push_back(3'b001);
    wait_grant("t6_unforced", 12, w, g);

    // Asynchronous reset mid-transaction returns the bus to idle at once.
    bus.ss_L_ports = 3'b110;
    bus.sck_ports  = 3'b001;
    #1;
    check("ar_ss_L_active", bus.ss_L, 0);
    #2;
    rst_L = 1'b0;
    #1;
    check("ar_grant", bus.grant, 0);
    check("ar_ss_L", bus.ss_L, 1);
    check("ar_sck", bus.sck, 0);
    check("ar_busy", bus.busy, 0);
    step(1);
    rst_L = 1'b1;
    step(1);

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
